// File: rtl/wb_arb_if.sv
// Bus bundle for wb_port_arbiter: two requester channels in, one buffered
// write-back channel out. The arbiter takes the slave modport; whatever
// drives requests and consumes write-backs takes the master modport.
interface wb_arb_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic [TAG_W-1:0]  in0_tag;
  logic              in0_ready;
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic [TAG_W-1:0]  in1_tag;
  logic              in1_ready;
  logic              mux_sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_src;
  logic              out_ready;

  modport slave (
    input  in0_valid, in0_data, in0_tag, in1_valid, in1_data, in1_tag, out_ready,
    output in0_ready, in1_ready, mux_sel, out_valid, out_data, out_tag, out_src
  );

  modport master (
    output in0_valid, in0_data, in0_tag, in1_valid, in1_data, in1_tag, out_ready,
    input  in0_ready, in1_ready, mux_sel, out_valid, out_data, out_tag, out_src
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two-requester arbiter for the shared register-file write-back port.
// Picks a winner combinationally (mux_sel) and captures it into a one-entry
// output buffer handshaked with the write-back stage.
// Optional macro WB_ARB_FIXED_PRIO_EN: a both-valid tie always goes to port 0
// (port 1 may starve). Default build is round-robin.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic      clk,
  input  logic      rst,
  wb_arb_if.slave   bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              grant;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] data_q;
  logic [TAG_W-1:0]  tag_q;
  logic              src_q;

  // Grant decision; with nobody requesting (or in reset) the selector parks on last_grant.
  always_comb begin
    grant = last_grant_q;
    if (!rst) begin
      if (bus.in0_valid && bus.in1_valid) begin
`ifdef WB_ARB_FIXED_PRIO_EN
        grant = 1'b0;
`else
        grant = ~last_grant_q;
`endif
      end else if (bus.in0_valid) begin
        grant = 1'b0;
      end else if (bus.in1_valid) begin
        grant = 1'b1;
      end
    end
  end

  // A slot is free when empty or when the current entry drains this cycle.
  always_comb begin
    can_accept = !rst && ((state_q == EMPTY) || bus.out_ready);
    accept     = can_accept && (bus.in0_valid || bus.in1_valid);
  end

  // Buffer occupancy next state; drain and refill in the same cycle keeps it FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (accept) state_d = FULL;
               else if (bus.out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Capture winner and remember who won; idle or stalled cycles leave last_grant alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      tag_q        <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      data_q       <= grant ? bus.in1_data : bus.in0_data;
      tag_q        <= grant ? bus.in1_tag  : bus.in0_tag;
      src_q        <= grant;
      last_grant_q <= grant;
    end
  end

  assign bus.mux_sel   = grant;
  assign bus.in0_ready = can_accept && !grant && bus.in0_valid;
  assign bus.in1_ready = can_accept &&  grant && bus.in1_valid;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic.
// A transaction-level model predicts grants and pushes expected write-backs;
// a separate monitor pops and compares them when the output drains.
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              src;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_arb_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  wb_port_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  wb_t exp_q[$];

  // requester-side pending transactions (held until accepted)
  logic              p_v[2];
  logic [DATA_W-1:0] p_d[2];
  logic [TAG_W-1:0]  p_t[2];
  logic              keep[2];

  // model state: buffer occupied, who was served last, previous cycle in reset
  bit m_full = 1'b0;
  bit m_last = 1'b1;
  bit m_rstq = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic load(input int i, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    p_v[i] = 1'b1;
    p_d[i] = d;
    p_t[i] = t;
  endtask

  // One clock: drive, predict and check at mid-cycle, advance model at the edge.
  task automatic step(input bit r, input bit ordy);
    bit space, acc;
    int w;
    #1;
    rst           = r;
    bus.out_ready = ordy;
    bus.in0_valid = p_v[0]; bus.in0_data = p_d[0]; bus.in0_tag = p_t[0];
    bus.in1_valid = p_v[1]; bus.in1_data = p_d[1]; bus.in1_tag = p_t[1];
    @(negedge clk);
    #1;
    if (r) begin
      chk("rst_in0_ready", {31'd0, bus.in0_ready}, 32'd0);
      chk("rst_in1_ready", {31'd0, bus.in1_ready}, 32'd0);
      if (m_rstq) begin
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mux_sel",   {31'd0, bus.mux_sel},   32'd1);
        chk("rst_out_data",  bus.out_data,           32'd0);
      end
    end else begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_full});
      space = !m_full || ordy;
      if (p_v[0] && p_v[1]) begin
`ifdef WB_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = m_last ? 0 : 1;
`endif
      end else if (p_v[0]) w = 0;
      else if (p_v[1]) w = 1;
      else w = m_last ? 1 : 0;
      acc = space && (p_v[0] || p_v[1]);
      chk("mux_sel",   {31'd0, bus.mux_sel},   w);
      chk("in0_ready", {31'd0, bus.in0_ready}, {31'd0, acc && w == 0});
      chk("in1_ready", {31'd0, bus.in1_ready}, {31'd0, acc && w == 1});
      if (acc) begin
        exp_q.push_back('{data: p_d[w], tag: p_t[w], src: w[0]});
        p_v[w] = keep[w];
        m_last = w[0];
        m_full = 1'b1;
      end else if (ordy) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    if (r) begin
      m_full = 1'b0;
      m_last = 1'b1;
      exp_q.delete();
    end
    m_rstq = r;
  endtask

  // Monitor: every drain must match the oldest predicted entry; stalled output must hold.
  initial begin : monitor
    wb_t e;
    bit hold = 1'b0;
    logic [DATA_W-1:0] hd;
    logic [TAG_W-1:0]  ht;
    logic              hs;
    forever begin
      @(negedge clk);
      if (hold && !rst) begin
        chk("stall_data", bus.out_data, hd);
        chk("stall_tag",  {27'd0, bus.out_tag}, {27'd0, ht});
        chk("stall_src",  {31'd0, bus.out_src}, {31'd0, hs});
      end
      hold = bus.out_valid && !bus.out_ready && !rst;
      hd = bus.out_data; ht = bus.out_tag; hs = bus.out_src;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("drain_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_tag",  {27'd0, bus.out_tag}, {27'd0, e.tag});
          chk("out_src",  {31'd0, bus.out_src}, {31'd0, e.src});
        end
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 1'b0; p_d[i] = '0; p_t[i] = '0; keep[i] = 1'b0;
    end
    bus.in0_valid = 1'b0; bus.in0_data = '0; bus.in0_tag = '0;
    bus.in1_valid = 1'b0; bus.in1_data = '0; bus.in1_tag = '0;
    bus.out_ready = 1'b0;

    // reset with both requesters asserting
    load(0, 32'h0000_1100, 5'd5);
    load(1, 32'h0000_0011, 5'd3);
    step(1, 0);
    step(1, 0);

    // continuous contention, output always ready
    keep[0] = 1'b1; keep[1] = 1'b1;
    for (int k = 0; k < 4; k++) step(0, 1);
    keep[0] = 1'b0; keep[1] = 1'b0;
    for (int k = 0; k < 4; k++) step(0, 1);

    // single request on port 0
    load(0, 32'h0000_1100, 5'd5);
    step(0, 1);
    step(0, 1);

    // backpressure: fill, stall with port 1 waiting, then drain+accept together
    load(0, 32'hCAFE_0001, 5'd7);
    step(0, 1);
    load(1, 32'hBEEF_0002, 5'd0);
    for (int k = 0; k < 3; k++) step(0, 0);
    step(0, 1);
    // drain only, then idle to observe parked selector
    step(0, 1);
    step(0, 0);

    // reset while full and stalled; first tie afterwards goes to port 0
    load(1, 32'h1234_5678, 5'd9);
    step(0, 1);
    step(0, 0);
    load(0, 32'hAAAA_0000, 5'd1);
    load(1, 32'h5555_0000, 5'd2);
    step(1, 0);
    step(0, 1);
    step(0, 1);
    step(0, 1);

    // random traffic with occasional reset
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++)
        if (!p_v[i] && $urandom_range(0, 2) != 0)
          load(i, $urandom(), 5'($urandom_range(0, 31)));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 6; k++) step(0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
